system_controller: RTL and testbench
====================================

# system_controller

Command sequencer between the UART receive path and the register file, ALU and UART transmit path, all in the reference-clock domain. Consumes synchronized received bytes, decodes the four frame types (0xAA register write, 0xBB register read, 0xCC ALU with operands, 0xDD ALU without operands), and drives the register file and ALU. Queues response bytes to the transmitter: one byte for a read, and low then high result byte for an ALU operation.

## Interface
- DATA_WIDTH, 8, byte and register width
- REGISTER_FILE_DEPTH, 16, register count; ADDRESS_WIDTH = $clog2(depth)
- ALU_FUNCTION_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles (used only with the timeout feature)
- clk  in  1  reference clock; single clock, everything on posedge
- reset  in  1  asynchronous, active-low
- rx_data  in  DATA_WIDTH  synchronized received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- reg_address  out  ADDRESS_WIDTH  register file address
- reg_write_enable  out  1  one-cycle write strobe
- reg_read_enable  out  1  one-cycle read strobe
- reg_write_data  out  DATA_WIDTH  write data
- reg_read_data  in  DATA_WIDTH  read data
- reg_read_data_valid  in  1  read data strobe, one cycle after reg_read_enable
- alu_enable  out  1  one-cycle start strobe
- alu_function  out  ALU_FUNCTION_WIDTH  held from func byte until result captured
- alu_clk_gate_enable  out  1  high from func byte through result capture
- alu_result  in  2*DATA_WIDTH  ALU result
- alu_result_valid  in  1  result strobe
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_valid  out  1  held until accepted
- tx_ready  in  1  byte is transferred in a cycle where tx_valid and tx_ready are both high

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, TX_LOW, TX_HIGH, TX_READ.
- IDLE:
  - 0xAA goes to WR_ADDR; 0xBB to RD_ADDR; 0xCC to ALU_A; 0xDD to ALU_FUNC.
  - Any other byte is ignored.
- Write (0xAA):
  - WR_ADDR latches the address (low ADDRESS_WIDTH bits).
  - WR_DATA raises reg_write_enable, then returns to IDLE.
- Read (0xBB):
  - RD_ADDR raises reg_read_enable and goes to RD_WAIT.
  - On reg_read_data_valid, the data is captured and the block goes to TX_READ.
- ALU with operands (0xCC):
  - ALU_A writes the byte to address 0.
  - ALU_B writes the byte to address 1.
  - Then ALU_FUNC.
- ALU_FUNC: latches the low ALU_FUNCTION_WIDTH bits, raises alu_enable and alu_clk_gate_enable, and goes to ALU_WAIT.
- ALU_WAIT: on alu_result_valid, captures the 16-bit result, drops the clock gate, and goes to TX_LOW.
- Transmit:
  - TX_LOW sends result[7:0], then TX_HIGH.
  - TX_HIGH sends result[15:8], then IDLE.
  - TX_READ sends the captured read data, then IDLE.
- rx_valid in RD_WAIT, ALU_WAIT or any TX state: the byte is dropped; no buffering.

## Timing
- Reset values: all strobes 0, tx_valid 0, alu_clk_gate_enable 0, tx_data 0, reg_address 0, reg_write_data 0, alu_function 0, state IDLE.
- All outputs are registered. A strobe asserts in the cycle after the rx_valid that triggers it and lasts exactly one cycle.
- Read latency: rx_valid(addr) at cycle N gives reg_read_enable at N+1, read data at N+2, tx_valid at N+3.
- ALU latency: alu_enable at N+1 after the func byte. tx_valid rises the cycle after alu_result_valid.
- tx_valid is asserted the cycle after the previous byte's acceptance. tx_valid and tx_data stay stable until tx_ready.
- tx_ready low indefinitely: the state is held; there is no timeout in TX states.
- Reset asserted mid-operation: immediate return to IDLE; any pending transmission or strobe is aborted.

## Configuration
- SYSTEM_CONTROLLER_TIMEOUT_EN defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUNC, cleared on each rx_valid.
  - On reaching TIMEOUT_CYCLES-1 the block returns to IDLE with no strobe; partial frames are discarded.
- Not defined: no counter; the block waits indefinitely for the next byte.

## Structure
- Package system_controller_pkg holds:
  - the state enum;
  - command constants WRITE_COMMAND=8'hAA, READ_COMMAND=8'hBB, ALU_OPERANDS_COMMAND=8'hCC, ALU_NO_OPERANDS_COMMAND=8'hDD;
  - operand addresses OPERAND_A_ADDRESS=0, OPERAND_B_ADDRESS=1.
- Single module; no sub-module. The timeout counter is inline under the macro.

## Test plan
- AA, 05, 3C → one reg_write_enable pulse with address 5, data 3C; state returns to IDLE.
- BB, 05, then reg_read_data=3C one cycle after read_enable → tx_data=3C; tx_valid held until tx_ready.
- CC, 0A, 14, 00 (add), result 001E → writes 0A@0 and 14@1, one alu_enable pulse with function 0, transmits 1E then 00.
- DD, 02 (mult) with result 00C8 → alu_enable, transmits C8 then 00; byte 55 sent during ALU_WAIT is ignored.
- Unknown byte 77 in IDLE → no output activity. Reset asserted during TX_HIGH → all outputs return to reset values.
- Timeout feature enabled: AA, 05, then silence for TIMEOUT_CYCLES → back in IDLE; a following BB, 05 performs a read of address 5.

Source files
------------

// File: rtl/system_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_controller_pkg
// Description : Shared types and constants for the command sequencer:
//               FSM state encoding, frame command bytes, operand addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package system_controller_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    ALU_A    = 4'd5,
    ALU_B    = 4'd6,
    ALU_FUNC = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LOW   = 4'd9,
    TX_HIGH  = 4'd10,
    TX_READ  = 4'd11
  } state_t;

  localparam logic [7:0] WRITE_COMMAND           = 8'hAA;
  localparam logic [7:0] READ_COMMAND            = 8'hBB;
  localparam logic [7:0] ALU_OPERANDS_COMMAND    = 8'hCC;
  localparam logic [7:0] ALU_NO_OPERANDS_COMMAND = 8'hDD;

  localparam int unsigned OPERAND_A_ADDRESS = 0;
  localparam int unsigned OPERAND_B_ADDRESS = 1;

endpackage
`default_nettype wire

// File: rtl/system_controller.sv
`default_nettype none
// ============================================================================
// Module      : system_controller
// Description : Command sequencer between the UART receive path and the
//               register file, ALU and UART transmit path. Decodes write,
//               read and ALU frames and queues response bytes.
//               Optional macro SYSTEM_CONTROLLER_TIMEOUT_EN adds an
//               inter-byte timeout that discards partial frames.
// Revision    : 1.0 - initial release
// ============================================================================
module system_controller
  import system_controller_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int ALU_FUNCTION_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES      = 50000,
  localparam int ADDRESS_WIDTH      = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_valid,
  output logic [ADDRESS_WIDTH-1:0]      reg_address,
  output logic                          reg_write_enable,
  output logic                          reg_read_enable,
  output logic [DATA_WIDTH-1:0]         reg_write_data,
  input  logic [DATA_WIDTH-1:0]         reg_read_data,
  input  logic                          reg_read_data_valid,
  output logic                          alu_enable,
  output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
  output logic                          alu_clk_gate_enable,
  input  logic [2*DATA_WIDTH-1:0]       alu_result,
  input  logic                          alu_result_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready
);

  state_t                        r_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0]      r_reg_address, w_reg_address_next;
  logic [DATA_WIDTH-1:0]         r_reg_write_data, w_reg_write_data_next;
  logic                          r_reg_write_enable, w_reg_write_enable_next;
  logic                          r_reg_read_enable, w_reg_read_enable_next;
  logic                          r_alu_enable, w_alu_enable_next;
  logic [ALU_FUNCTION_WIDTH-1:0] r_alu_function, w_alu_function_next;
  logic                          r_alu_gate, w_alu_gate_next;
  logic [2*DATA_WIDTH-1:0]       r_result, w_result_next;
  logic [DATA_WIDTH-1:0]         r_tx_data, w_tx_data_next;
  logic                          r_tx_valid, w_tx_valid_next;
  logic                          w_tx_accept;
  logic                          w_timeout;

  assign w_tx_accept = r_tx_valid & tx_ready;

`ifdef SYSTEM_CONTROLLER_TIMEOUT_EN
  localparam int c_count_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_count_width-1:0] c_count_max = c_count_width'(TIMEOUT_CYCLES - 1);

  logic [c_count_width-1:0] r_timeout_count;
  logic                     w_timed_state;

  // Only states that wait on the next frame byte are subject to the timeout.
  assign w_timed_state = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                         (r_state == RD_ADDR) || (r_state == ALU_A)   ||
                         (r_state == ALU_B)   || (r_state == ALU_FUNC);
  assign w_timeout     = w_timed_state && !rx_valid && (r_timeout_count == c_count_max);

  // Inter-byte silence counter, restarted by every received byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_count <= '0;
    end else if (!w_timed_state || rx_valid || w_timeout) begin
      r_timeout_count <= '0;
    end else begin
      r_timeout_count <= r_timeout_count + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-output decode; strobes default low every cycle.
  always_comb begin
    w_state_next            = r_state;
    w_reg_address_next      = r_reg_address;
    w_reg_write_data_next   = r_reg_write_data;
    w_reg_write_enable_next = 1'b0;
    w_reg_read_enable_next  = 1'b0;
    w_alu_enable_next       = 1'b0;
    w_alu_function_next     = r_alu_function;
    w_alu_gate_next         = r_alu_gate;
    w_result_next           = r_result;
    w_tx_data_next          = r_tx_data;
    w_tx_valid_next         = r_tx_valid;

    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == WRITE_COMMAND)                w_state_next = WR_ADDR;
          else if (rx_data == READ_COMMAND)            w_state_next = RD_ADDR;
          else if (rx_data == ALU_OPERANDS_COMMAND)    w_state_next = ALU_A;
          else if (rx_data == ALU_NO_OPERANDS_COMMAND) w_state_next = ALU_FUNC;
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          w_reg_address_next = rx_data[ADDRESS_WIDTH-1:0];
          w_state_next       = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          w_reg_write_data_next   = rx_data;
          w_reg_write_enable_next = 1'b1;
          w_state_next            = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          w_reg_address_next     = rx_data[ADDRESS_WIDTH-1:0];
          w_reg_read_enable_next = 1'b1;
          w_state_next           = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (reg_read_data_valid) begin
          w_tx_data_next  = reg_read_data;
          w_tx_valid_next = 1'b1;
          w_state_next    = TX_READ;
        end
      end
      ALU_A: begin
        if (rx_valid) begin
          w_reg_address_next      = ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
          w_reg_write_data_next   = rx_data;
          w_reg_write_enable_next = 1'b1;
          w_state_next            = ALU_B;
        end
      end
      ALU_B: begin
        if (rx_valid) begin
          w_reg_address_next      = ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
          w_reg_write_data_next   = rx_data;
          w_reg_write_enable_next = 1'b1;
          w_state_next            = ALU_FUNC;
        end
      end
      ALU_FUNC: begin
        if (rx_valid) begin
          w_alu_function_next = rx_data[ALU_FUNCTION_WIDTH-1:0];
          w_alu_enable_next   = 1'b1;
          w_alu_gate_next     = 1'b1;
          w_state_next        = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (alu_result_valid) begin
          w_result_next   = alu_result;
          w_alu_gate_next = 1'b0;
          w_tx_data_next  = alu_result[DATA_WIDTH-1:0];
          w_tx_valid_next = 1'b1;
          w_state_next    = TX_LOW;
        end
      end
      TX_LOW: begin
        // High byte is presented the cycle after the low byte is taken.
        if (w_tx_accept) begin
          w_tx_data_next = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
          w_state_next   = TX_HIGH;
        end
      end
      TX_HIGH, TX_READ: begin
        if (w_tx_accept) begin
          w_tx_valid_next = 1'b0;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_timeout) begin
      w_state_next = IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= IDLE;
      r_reg_address      <= '0;
      r_reg_write_data   <= '0;
      r_reg_write_enable <= 1'b0;
      r_reg_read_enable  <= 1'b0;
      r_alu_enable       <= 1'b0;
      r_alu_function     <= '0;
      r_alu_gate         <= 1'b0;
      r_result           <= '0;
      r_tx_data          <= '0;
      r_tx_valid         <= 1'b0;
    end else begin
      r_state            <= w_state_next;
      r_reg_address      <= w_reg_address_next;
      r_reg_write_data   <= w_reg_write_data_next;
      r_reg_write_enable <= w_reg_write_enable_next;
      r_reg_read_enable  <= w_reg_read_enable_next;
      r_alu_enable       <= w_alu_enable_next;
      r_alu_function     <= w_alu_function_next;
      r_alu_gate         <= w_alu_gate_next;
      r_result           <= w_result_next;
      r_tx_data          <= w_tx_data_next;
      r_tx_valid         <= w_tx_valid_next;
    end
  end

  assign reg_address         = r_reg_address;
  assign reg_write_data      = r_reg_write_data;
  assign reg_write_enable    = r_reg_write_enable;
  assign reg_read_enable     = r_reg_read_enable;
  assign alu_enable          = r_alu_enable;
  assign alu_function        = r_alu_function;
  assign alu_clk_gate_enable = r_alu_gate;
  assign tx_data             = r_tx_data;
  assign tx_valid            = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_system_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_controller
// Description : Directed self-checking bench for system_controller.
//               Timeout scenario is built when SYSTEM_CONTROLLER_TIMEOUT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_system_controller;
  import system_controller_pkg::*;

  localparam int c_timeout = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [3:0]  reg_address;
  logic        reg_write_enable;
  logic        reg_read_enable;
  logic [7:0]  reg_write_data;
  logic [7:0]  reg_read_data = '0;
  logic        reg_read_data_valid = 1'b0;
  logic        alu_enable;
  logic [3:0]  alu_function;
  logic        alu_clk_gate_enable;
  logic [15:0] alu_result = '0;
  logic        alu_result_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int pass_count  = 0;
  int check_count = 0;

  system_controller #(
    .DATA_WIDTH(8), .REGISTER_FILE_DEPTH(16), .ALU_FUNCTION_WIDTH(4),
    .TIMEOUT_CYCLES(c_timeout)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_address(reg_address), .reg_write_enable(reg_write_enable),
    .reg_read_enable(reg_read_enable), .reg_write_data(reg_write_data),
    .reg_read_data(reg_read_data), .reg_read_data_valid(reg_read_data_valid),
    .alu_enable(alu_enable), .alu_function(alu_function),
    .alu_clk_gate_enable(alu_clk_gate_enable), .alu_result(alu_result),
    .alu_result_valid(alu_result_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Present one byte for one cycle; returns at the negedge after it is consumed.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_count++;
    if ({reg_write_enable, reg_read_enable, alu_enable, alu_clk_gate_enable, tx_valid} !== 5'b0)
      $display("FAIL reset_strobes got=%b want=00000",
               {reg_write_enable, reg_read_enable, alu_enable, alu_clk_gate_enable, tx_valid});
    else pass_count++;
    check_count++;
    if ({tx_data, reg_address, reg_write_data, alu_function} !== 24'h0)
      $display("FAIL reset_values got=%h want=000000", {tx_data, reg_address, reg_write_data, alu_function});
    else pass_count++;
    reset = 1'b1;
  endtask

  task automatic test_write();
    send(8'hAA);
    send(8'h05);
    check_count++;
    if (reg_write_enable !== 1'b0) $display("FAIL wr_early_strobe got=%b want=0", reg_write_enable);
    else pass_count++;
    send(8'h3C);
    check_count++;
    if ({reg_write_enable, reg_address, reg_write_data} !== {1'b1, 4'h5, 8'h3C})
      $display("FAIL wr_pulse got=%b/%h/%h want=1/5/3c", reg_write_enable, reg_address, reg_write_data);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (reg_write_enable !== 1'b0 || dut.r_state !== IDLE)
      $display("FAIL wr_end got=%b/%0d want=0/%0d", reg_write_enable, dut.r_state, IDLE);
    else pass_count++;
  endtask

  task automatic test_read();
    send(8'hBB);
    send(8'h05);
    check_count++;
    if ({reg_read_enable, reg_address} !== {1'b1, 4'h5})
      $display("FAIL rd_enable got=%b/%h want=1/5", reg_read_enable, reg_address);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (reg_read_enable !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL rd_single got=%b/%b want=0/0", reg_read_enable, tx_valid);
    else pass_count++;
    reg_read_data = 8'h3C;
    reg_read_data_valid = 1'b1;
    @(negedge clk);
    reg_read_data_valid = 1'b0;
    reg_read_data = 8'h00;
    check_count++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h3C})
      $display("FAIL rd_tx got=%b/%h want=1/3c", tx_valid, tx_data);
    else pass_count++;
    repeat (3) @(negedge clk);
    check_count++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h3C})
      $display("FAIL rd_hold got=%b/%h want=1/3c", tx_valid, tx_data);
    else pass_count++;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check_count++;
    if (tx_valid !== 1'b0 || dut.r_state !== IDLE)
      $display("FAIL rd_done got=%b/%0d want=0/%0d", tx_valid, dut.r_state, IDLE);
    else pass_count++;
  endtask

  task automatic test_alu_operands();
    send(8'hCC);
    send(8'h0A);
    check_count++;
    if ({reg_write_enable, reg_address, reg_write_data} !== {1'b1, 4'h0, 8'h0A})
      $display("FAIL alu_opa got=%b/%h/%h want=1/0/0a", reg_write_enable, reg_address, reg_write_data);
    else pass_count++;
    send(8'h14);
    check_count++;
    if ({reg_write_enable, reg_address, reg_write_data} !== {1'b1, 4'h1, 8'h14})
      $display("FAIL alu_opb got=%b/%h/%h want=1/1/14", reg_write_enable, reg_address, reg_write_data);
    else pass_count++;
    send(8'h00);
    check_count++;
    if ({alu_enable, alu_clk_gate_enable, alu_function, reg_write_enable} !== {1'b1, 1'b1, 4'h0, 1'b0})
      $display("FAIL alu_start got=%b/%b/%h/%b want=1/1/0/0",
               alu_enable, alu_clk_gate_enable, alu_function, reg_write_enable);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if ({alu_enable, alu_clk_gate_enable} !== 2'b01)
      $display("FAIL alu_pulse got=%b/%b want=0/1", alu_enable, alu_clk_gate_enable);
    else pass_count++;
    alu_result = 16'h001E;
    alu_result_valid = 1'b1;
    @(negedge clk);
    alu_result_valid = 1'b0;
    alu_result = 16'h0000;
    check_count++;
    if ({tx_valid, tx_data, alu_clk_gate_enable} !== {1'b1, 8'h1E, 1'b0})
      $display("FAIL alu_low got=%b/%h/%b want=1/1e/0", tx_valid, tx_data, alu_clk_gate_enable);
    else pass_count++;
    tx_ready = 1'b1;
    @(negedge clk);
    check_count++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h00})
      $display("FAIL alu_high got=%b/%h want=1/00", tx_valid, tx_data);
    else pass_count++;
    @(negedge clk);
    tx_ready = 1'b0;
    check_count++;
    if (tx_valid !== 1'b0 || dut.r_state !== IDLE)
      $display("FAIL alu_done got=%b/%0d want=0/%0d", tx_valid, dut.r_state, IDLE);
    else pass_count++;
  endtask

  task automatic test_alu_no_operands();
    send(8'hDD);
    send(8'h02);
    check_count++;
    if ({alu_enable, alu_function, reg_write_enable} !== {1'b1, 4'h2, 1'b0})
      $display("FAIL mul_start got=%b/%h/%b want=1/2/0", alu_enable, alu_function, reg_write_enable);
    else pass_count++;
    send(8'h55);
    check_count++;
    if ({reg_write_enable, reg_read_enable, alu_enable, tx_valid} !== 4'b0 || dut.r_state !== ALU_WAIT)
      $display("FAIL mul_drop got=%b/%0d want=0000/%0d",
               {reg_write_enable, reg_read_enable, alu_enable, tx_valid}, dut.r_state, ALU_WAIT);
    else pass_count++;
    alu_result = 16'h00C8;
    alu_result_valid = 1'b1;
    @(negedge clk);
    alu_result_valid = 1'b0;
    check_count++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hC8})
      $display("FAIL mul_low got=%b/%h want=1/c8", tx_valid, tx_data);
    else pass_count++;
    tx_ready = 1'b1;
    @(negedge clk);
    check_count++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h00})
      $display("FAIL mul_high got=%b/%h want=1/00", tx_valid, tx_data);
    else pass_count++;
    @(negedge clk);
    tx_ready = 1'b0;
    check_count++;
    if (tx_valid !== 1'b0) $display("FAIL mul_done got=%b want=0", tx_valid);
    else pass_count++;
  endtask

  task automatic test_unknown();
    send(8'h77);
    check_count++;
    if ({reg_write_enable, reg_read_enable, alu_enable, tx_valid} !== 4'b0 || dut.r_state !== IDLE)
      $display("FAIL unknown got=%b/%0d want=0000/%0d",
               {reg_write_enable, reg_read_enable, alu_enable, tx_valid}, dut.r_state, IDLE);
    else pass_count++;
  endtask

  task automatic test_reset_mid_tx();
    send(8'hDD);
    send(8'h03);
    alu_result = 16'h1234;
    alu_result_valid = 1'b1;
    @(negedge clk);
    alu_result_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check_count++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h12} || dut.r_state !== TX_HIGH)
      $display("FAIL rst_pre got=%b/%h/%0d want=1/12/%0d", tx_valid, tx_data, dut.r_state, TX_HIGH);
    else pass_count++;
    #1 reset = 1'b0;
    #1;
    check_count++;
    if ({tx_valid, tx_data, alu_clk_gate_enable, reg_address, reg_write_data, alu_function} !== 26'h0 ||
        dut.r_state !== IDLE)
      $display("FAIL rst_mid got=%h/%0d want=0/%0d",
               {tx_valid, tx_data, alu_clk_gate_enable, reg_address, reg_write_data, alu_function},
               dut.r_state, IDLE);
    else pass_count++;
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef SYSTEM_CONTROLLER_TIMEOUT_EN
  task automatic test_timeout();
    send(8'hAA);
    send(8'h05);
    repeat (10) @(negedge clk);
    check_count++;
    if (dut.r_state !== WR_DATA) $display("FAIL to_wait got=%0d want=%0d", dut.r_state, WR_DATA);
    else pass_count++;
    repeat (c_timeout) @(negedge clk);
    check_count++;
    if (dut.r_state !== IDLE || reg_write_enable !== 1'b0)
      $display("FAIL to_idle got=%0d/%b want=%0d/0", dut.r_state, reg_write_enable, IDLE);
    else pass_count++;
    send(8'hBB);
    send(8'h05);
    check_count++;
    if ({reg_read_enable, reg_address} !== {1'b1, 4'h5})
      $display("FAIL to_read got=%b/%h want=1/5", reg_read_enable, reg_address);
    else pass_count++;
    @(negedge clk);
    reg_read_data = 8'h3C;
    reg_read_data_valid = 1'b1;
    @(negedge clk);
    reg_read_data_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_operands();
    test_alu_no_operands();
    test_unknown();
    test_reset_mid_tx();
`ifdef SYSTEM_CONTROLLER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
`default_nettype wire
